serial_bit_feeder: RTL and testbench

Parallel-to-serial stage upstream of the Mealy zero detector. Accepts WIDTH-bit words through a valid/ready handshake and drives them one bit per clock onto a serial line that connects directly to the detector's `x_in`. A one-word holding buffer lets back-to-back words stream with no idle gap. An optional even-parity bit can be appended after each word.

---
 rtl/serial_bit_feeder.sv | 153 +++++++++++++++
 tb/tb_serial_bit_feeder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_feeder.sv
// -----------------------------------------------------------------------------
// serial_bit_feeder
//
// Parallel-to-serial stage feeding the Mealy zero detector. Words arrive on a
// valid/ready handshake and leave one bit per clock on x_out. A one-word
// holding buffer lets consecutive words stream with no idle cycle between them.
//
// Optional feature macro: SERIAL_PARITY_EN
//   When defined, an even-parity bit (XOR of the word) follows the WIDTH data
//   bits, and word_done moves to that parity cycle.
//
// Parameters:
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1 = bit WIDTH-1 leaves first, 0 = bit 0 leaves first
//   IDLE_LEVEL level driven on x_out while no bit is being sent
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high reset
//   data_in    word to serialize
//   load       data_in is valid this cycle
//   ready      block can accept a word this cycle
//   x_out      serial bit (drives the detector's x_in)
//   x_valid    x_out carries a data or parity bit
//   word_done  one-cycle pulse while the final bit of a word is on x_out
//   busy       shifter active or holding buffer occupied
// -----------------------------------------------------------------------------
module serial_bit_feeder #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             x_out,
    output logic             x_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int            CW       = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

`ifdef SERIAL_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] sr;        // current word; the bit on x_out sits at the exit end
    logic [WIDTH-1:0] hold_buf;  // one-word holding buffer
    logic             buf_full;
    logic [CW-1:0]    cnt;       // index of the data bit currently on x_out
`ifdef SERIAL_PARITY_EN
    logic             par;       // even parity of the word in the shifter
`endif

    logic             accept;
    logic             last_bit;
    logic             start;
    logic             to_buf;
    logic [WIDTH-1:0] start_word;

    // Bit that leaves first for a given word.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Move the next bit to the exit end of the shift register.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
    endfunction

    // NOTE: ready depends only on the registered buffer flag, never on load,
    // so an upstream block may compute load from ready without a comb loop.
    assign ready  = !buf_full;
    assign accept = load && ready;
    assign busy   = (state != IDLE) || buf_full;

`ifdef SERIAL_PARITY_EN
    assign last_bit = (state == PARITY);
`else
    assign last_bit = (state == SHIFT) && (cnt == LAST_CNT);
`endif

    // A new word enters the shifter whenever the line is free next cycle:
    // from the buffer if it holds one, otherwise straight from data_in.
    // The buffer is only ever full while the shifter is mid-word.
    assign start      = ((state == IDLE) || last_bit) && (buf_full || accept);
    assign start_word = buf_full ? hold_buf : data_in;
    assign to_buf     = accept && !((state == IDLE) || last_bit);

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: sr, hold_buf and parity are pure datapath; they are only
            // read after a start/to_buf writes them, so they need no reset.
            state     <= IDLE;
            buf_full  <= 1'b0;
            cnt       <= '0;
            x_out     <= IDLE_LEVEL;
            x_valid   <= 1'b0;
            word_done <= 1'b0;
        end else begin
            if (to_buf) begin
                hold_buf <= data_in;
                buf_full <= 1'b1;
            end else if (start && buf_full) begin
                buf_full <= 1'b0;
            end

            if (start) begin
                state     <= SHIFT;
                sr        <= start_word;
                cnt       <= '0;
                x_out     <= first_bit(start_word);
                x_valid   <= 1'b1;
                word_done <= 1'b0;  // WIDTH >= 2, so bit 0 is never the last
`ifdef SERIAL_PARITY_EN
                par       <= ^start_word;
`endif
            end else if (last_bit) begin
                state     <= IDLE;
                x_out     <= IDLE_LEVEL;
                x_valid   <= 1'b0;
                word_done <= 1'b0;
            end else if (state == SHIFT) begin
`ifdef SERIAL_PARITY_EN
                if (cnt == LAST_CNT) begin
                    state     <= PARITY;
                    x_out     <= par;
                    word_done <= 1'b1;
                end else begin
                    sr        <= shift_once(sr);
                    cnt       <= cnt + CW'(1);
                    x_out     <= first_bit(shift_once(sr));
                    word_done <= 1'b0;
                end
`else
                sr        <= shift_once(sr);
                cnt       <= cnt + CW'(1);
                x_out     <= first_bit(shift_once(sr));
                // Registered pulse: raise it on the edge entering the last bit.
                word_done <= (cnt == LAST_CNT - CW'(1));
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// -----------------------------------------------------------------------------
// tb_serial_bit_feeder
//
// Self-checking bench for serial_bit_feeder with default parameters
// (WIDTH=8, MSB first, idle level 1). A queue-based model tracks the bits
// still owed on the line and the word waiting in the buffer; every cycle the
// DUT outputs are compared against it. Directed tests add literal checks.
// Build with +define+SERIAL_PARITY_EN to cover the parity variant.
// -----------------------------------------------------------------------------
module tb_serial_bit_feeder;

`ifdef SERIAL_PARITY_EN
    localparam int BITS = 9;
`else
    localparam int BITS = 8;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'hFF;
    logic       load = 1'b1;
    logic       ready, x_out, x_valid, word_done, busy;

    serial_bit_feeder dut (
        .clock     (clock),
        .reset     (reset),
        .data_in   (data_in),
        .load      (load),
        .ready     (ready),
        .x_out     (x_out),
        .x_valid   (x_valid),
        .word_done (word_done),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    bit         cur[$];   // bits still to appear on the line, head = this cycle
    logic [7:0] pend[$];  // accepted words not yet started
    bit         cmp_en = 1'b0;

    task automatic expand(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) cur.push_back(w[i]);
`ifdef SERIAL_PARITY_EN
        cur.push_back(^w);
`endif
    endtask

    always @(posedge clock) begin
        bit acc;
        if (reset) begin
            cur.delete();
            pend.delete();
        end else begin
            acc = load && (pend.size() == 0);
            if (cur.size() > 0) void'(cur.pop_front());
            if (cur.size() == 0) begin
                if (pend.size() > 0) expand(pend.pop_front());
                else if (acc) expand(data_in);
            end else if (acc) begin
                pend.push_back(data_in);
            end
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            logic ev;
            ev = (cur.size() > 0);
            check("x_valid",   x_valid,   ev);
            check("x_out",     x_out,     ev ? cur[0] : 1'b1);
            check("word_done", word_done, cur.size() == 1);
            check("busy",      busy,      ev || (pend.size() > 0));
            check("ready",     ready,     pend.size() == 0);
        end
    end

    // ---------------- line monitors ----------------
    int run = 0, last_run = 0, done_cnt = 0, rdy_low = 0;
    always @(negedge clock) begin
        if (cmp_en) begin
            if (x_valid) run++;
            else if (run > 0) begin
                last_run = run;
                run = 0;
            end
            if (word_done) done_cnt++;
            if (!ready) rdy_low++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_one(input logic [7:0] w, input logic [8:0] exp_bits, input string nm);
        logic [8:0] got;
        int done_at, wd_n;
        @(negedge clock); load = 1'b1; data_in = w;
        @(negedge clock); load = 1'b0; data_in = 8'h00;  // first bit on line now
        got = '0; done_at = -1; wd_n = 0;
        for (int i = 0; i < BITS; i++) begin
            if (i > 0) @(negedge clock);
            got = {got[7:0], x_out};
            if (word_done) begin
                wd_n++;
                if (done_at < 0) done_at = i;
            end
        end
        check({nm, "_bits"}, got, exp_bits);
        check({nm, "_done_at"}, done_at, BITS - 1);
        check({nm, "_done_n"}, wd_n, 1);
        @(negedge clock);
        check({nm, "_idle_valid"}, x_valid, 1'b0);
        check({nm, "_idle_x"}, x_out, 1'b1);
    endtask

    logic [7:0] stim[$];

    // Hold load high; while ready is low present junk that must not be taken.
    task automatic stream();
        int k = 0, guard = 0;
        while (k < stim.size() && guard < 200) begin
            @(negedge clock);
            guard++;
            load = 1'b1;
            if (ready) begin
                data_in = stim[k];
                k++;
            end else begin
                data_in = 8'hEE;
            end
        end
        check("stream_accepted", k, stim.size());
        @(negedge clock); load = 1'b0; data_in = 8'h00;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (busy !== 1'b0 && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        check("idle_timeout", guard < 100, 1'b1);
        @(negedge clock);
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with load asserted: nothing may be accepted.
        @(posedge clock);
        cmp_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("rst_x_out", x_out, 1'b1);
            check("rst_valid", x_valid, 1'b0);
            check("rst_ready", ready, 1'b1);
            check("rst_busy",  busy, 1'b0);
        end
        reset = 1'b0; load = 1'b0; data_in = 8'h00;
        @(negedge clock);
        check("post_rst_valid", x_valid, 1'b0);

        // Single word, MSB first.
`ifdef SERIAL_PARITY_EN
        send_one(8'b1011_0010, 9'h164, "single");
`else
        send_one(8'b1011_0010, 9'h0B2, "single");
`endif

        // Gapless stream of three words.
        stim = '{8'h00, 8'hFF, 8'hA5};
        done_cnt = 0; rdy_low = 0;
        stream();
        wait_idle();
        check("stream3_run",  last_run, 3 * BITS);
        check("stream3_done", done_cnt, 3);
        check("stream3_rdy_low_seen", rdy_low > 0, 1'b1);

        // Buffer full: extra loads held off, none lost or duplicated.
        stim = '{8'h3C, 8'hC3, 8'h5A, 8'h96};
        done_cnt = 0;
        stream();
        wait_idle();
        check("stream4_run",  last_run, 4 * BITS);
        check("stream4_done", done_cnt, 4);

        // Reset mid-word with the buffer full.
        @(negedge clock); load = 1'b1; data_in = 8'h0F;
        @(negedge clock); load = 1'b1; data_in = 8'h55;  // goes to buffer
        @(negedge clock); load = 1'b0; data_in = 8'h00;
        @(negedge clock);
        @(negedge clock);
        check("pre_rst_ready", ready, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_x_out", x_out, 1'b1);
        check("mid_rst_valid", x_valid, 1'b0);
        check("mid_rst_busy",  busy, 1'b0);
        check("mid_rst_ready", ready, 1'b1);
        check("mid_rst_done",  word_done, 1'b0);
        reset = 1'b0;
`ifdef SERIAL_PARITY_EN
        send_one(8'h69, 9'h0D2, "after_rst");
        send_one(8'h07, 9'h00F, "par_07");
`else
        send_one(8'h69, 9'h069, "after_rst");
        send_one(8'h07, 9'h007, "word_07");
`endif

        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
